div_unit: RTL and testbench

- Parametrised multi-cycle restoring divider for the EX stage of the flow CPU. Serves DIV/DIVU.
- Produces a one-bit quotient per cycle; returns {remainder, quotient} for the HI/LO write path.
- The EX stage holds the pipeline stall request while `ready_o` is low after a start.
- Generalises the single-width datapath to any operand width `DATA_W`.

---
 rtl/div_unit.sv | 136 +++++++++++++
 tb/tb_div_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider (DIV/DIVU), one quotient bit per cycle.
// Ports: clk, rst (sync, active-low), signed_div_i, opdata1_i, opdata2_i,
//   start_i, annul_i -> result_o {rem, quo}, ready_o.
module div_unit #(
  parameter  int DATA_W = 32,
  localparam int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BYZERO,
    S_ON,
    S_END
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d;
  logic [DATA_W-1:0]   dsr_q, dsr_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic [DATA_W:0]     trial;
  logic                ge;
  logic                neg1, neg2;

  // Shifted remainder is always < 2*divisor, so bit DATA_W of the
  // difference is a reliable borrow flag.
  assign trial = {rem_q, dvd_q[DATA_W-1]} - {1'b0, dsr_q};
  assign ge    = ~trial[DATA_W];
  assign neg1  = signed_div_i & opdata1_i[DATA_W-1];
  assign neg2  = signed_div_i & opdata2_i[DATA_W-1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    ready_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            state_d = S_ON;
            dvd_d   = neg1 ? -opdata1_i : opdata1_i;
            dsr_d   = neg2 ? -opdata2_i : opdata2_i;
            rem_d   = '0;
            cnt_d   = '0;
            qneg_d  = neg1 ^ neg2;
            rneg_d  = neg1;
          end
        end
      end
      S_BYZERO: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_END;
          result_d = '0;
        end
      end
      S_ON: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d  = S_END;
          ready_d  = 1'b1;
          result_d = {rneg_q ? -rem_q : rem_q,
                      qneg_q ? -dvd_q : dvd_q};
        end else begin
          rem_d = ge ? trial[DATA_W-1:0]
                     : {rem_q[DATA_W-2:0], dvd_q[DATA_W-1]};
          dvd_d = {dvd_q[DATA_W-2:0], ge};
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_END: begin
        if (annul_i || !start_i) begin
          state_d = S_IDLE;
        end else begin
          ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors for div_unit at DATA_W=32 and DATA_W=8.
// Table-driven runs plus annul, ignored-start and mid-division reset sequences.
module tb_div_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sd32, st32, an32, rdy32;
  logic [31:0] a32, b32;
  logic [63:0] res32;
  logic        sd8, st8, an8, rdy8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;

  div_unit #(.DATA_W(32)) u32 (
    .clk(clk), .rst(rst), .signed_div_i(sd32),
    .opdata1_i(a32), .opdata2_i(b32),
    .start_i(st32), .annul_i(an32),
    .result_o(res32), .ready_o(rdy32)
  );

  div_unit #(.DATA_W(8)) u8 (
    .clk(clk), .rst(rst), .signed_div_i(sd8),
    .opdata1_i(a8), .opdata2_i(b8),
    .start_i(st8), .annul_i(an8),
    .result_o(res8), .ready_o(rdy8)
  );

  typedef struct {
    bit          w8;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] last32 = '0;
  logic [63:0] last8  = '0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] act_res(input bit w8);
    return w8 ? {24'b0, res8[15:8], 24'b0, res8[7:0]} : res32;
  endfunction

  function automatic logic act_rdy(input bit w8);
    return w8 ? rdy8 : rdy32;
  endfunction

  task automatic drive(input bit w8, input bit s, input logic [31:0] a,
                       input logic [31:0] b, input bit st, input bit an);
    if (w8) begin
      sd8 = s; a8 = a[7:0]; b8 = b[7:0]; st8 = st; an8 = an;
    end else begin
      sd32 = s; a32 = a; b32 = b; st32 = st; an32 = an;
    end
  endtask

  function automatic vec_t mk(input bit w8, input bit sgn,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] q, input logic [31:0] r,
                              input int lat, input string name);
    vec_t v;
    v.w8 = w8; v.sgn = sgn; v.a = a; v.b = b;
    v.q = q; v.r = r; v.lat = lat; v.name = name;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int cyc;
    bit seen;
    logic [63:0] exp;
    exp = v.w8 ? {24'b0, v.r[7:0], 24'b0, v.q[7:0]} : {v.r, v.q};
    @(negedge clk);
    drive(v.w8, v.sgn, v.a, v.b, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(v.w8, v.sgn, ~v.a, $urandom, 1'b1, 1'b0);
    cyc = 1;
    @(posedge clk); #1;
    seen = act_rdy(v.w8);
    while (!seen && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      seen = act_rdy(v.w8);
    end
    check({v.name, " latency"}, 64'(cyc), 64'(v.lat));
    check({v.name, " result"}, act_res(v.w8), exp);
    @(posedge clk); #1;
    check({v.name, " ready held"}, 64'(act_rdy(v.w8)), 64'd1);
    @(negedge clk);
    drive(v.w8, v.sgn, v.a, v.b, 1'b0, 1'b0);
    @(posedge clk); #1;
    check({v.name, " ready drop"}, 64'(act_rdy(v.w8)), 64'd0);
    check({v.name, " retained"}, act_res(v.w8), exp);
    if (v.w8) last8 = exp;
    else last32 = exp;
  endtask

  task automatic no_ready(input string nm, input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (rdy32 || rdy8) seen = 1'b1;
    end
    check(nm, 64'(seen), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

    vecs.push_back(mk(0, 0, 32'd100, 32'd7, 32'd14, 32'd2, 33, "u100/7"));
    vecs.push_back(mk(0, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD,
                      32'hFFFFFFFF, 33, "s-7/2"));
    vecs.push_back(mk(0, 1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD,
                      32'd1, 33, "s7/-2"));
    vecs.push_back(mk(0, 0, 32'd5, 32'd0, 32'd0, 32'd0, 2, "u5/0"));
    vecs.push_back(mk(0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,
                      32'd0, 33, "sMIN/-1"));
    vecs.push_back(mk(0, 0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF,
                      32'd0, 33, "uMAX/1"));
    vecs.push_back(mk(0, 0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF,
                      32'hF, 33, "uMAX/16"));
    vecs.push_back(mk(0, 1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,
                      32'hFFFFFFFE, 33, "s-100/-7"));
    vecs.push_back(mk(0, 0, 32'h80000000, 32'hFFFFFFFF, 32'd0,
                      32'h80000000, 33, "u2^31/MAX"));
    vecs.push_back(mk(0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 2, "u0/0"));
    vecs.push_back(mk(0, 0, 32'd3, 32'd5, 32'd0, 32'd3, 33, "u3/5"));
    vecs.push_back(mk(0, 1, 32'd0, 32'hFFFFFFFD, 32'd0, 32'd0, 33, "s0/-3"));
    vecs.push_back(mk(1, 0, 32'd200, 32'd3, 32'd66, 32'd2, 9, "w8 u200/3"));
    vecs.push_back(mk(1, 1, 32'h80, 32'h01, 32'h80, 32'h00, 9, "w8 s-128/1"));
    vecs.push_back(mk(1, 1, 32'h80, 32'hFF, 32'h80, 32'h00, 9, "w8 s-128/-1"));
    vecs.push_back(mk(1, 1, 32'hF9, 32'h02, 32'hFD, 32'hFF, 9, "w8 s-7/2"));
    vecs.push_back(mk(1, 0, 32'hFF, 32'h00, 32'h00, 32'h00, 2, "w8 u255/0"));

    repeat (3) @(posedge clk);
    #1;
    check("reset ready32", 64'(rdy32), 64'd0);
    check("reset result32", res32, 64'd0);
    check("reset ready8", 64'(rdy8), 64'd0);
    check("reset result8", 64'(res8), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // start together with annul in IDLE is ignored
    @(negedge clk);
    drive(1'b0, 1'b0, 32'd10, 32'd2, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'd10, 32'd2, 1'b0, 1'b0);
    no_ready("start+annul ignored", 40);
    check("start+annul result", res32, last32);

    // annul mid-division
    @(negedge clk);
    drive(1'b0, 1'b0, 32'd1000, 32'd3, 1'b1, 1'b0);
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'd1000, 32'd3, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("annul ready", 64'(rdy32), 64'd0);
    @(negedge clk);
    an32 = 1'b0;
    no_ready("annul no ready", 40);
    check("annul result kept", res32, last32);
    run_vec(mk(0, 0, 32'd9, 32'd4, 32'd2, 32'd1, 33, "u9/4 after annul"));

    // reset in the middle of a division
    @(negedge clk);
    drive(1'b0, 1'b0, 32'd50, 32'd5, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 32'd50, 32'd5, 1'b1, 1'b0);
    @(posedge clk);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midreset ready32", 64'(rdy32), 64'd0);
    check("midreset result32", res32, 64'd0);
    check("midreset ready8", 64'(rdy8), 64'd0);
    check("midreset result8", 64'(res8), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    no_ready("midreset no ready", 40);
    run_vec(vecs[0]);
    run_vec(vecs[12]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
